hp_rx_word_aligner: RTL and testbench

//  Downstream of the HP receive dock: consumes the 8-bit parallel words from the 1:8 deserializer
//  (rx_data on rx_clk) and finds the bit offset of a periodic sync byte.

---
 rtl/hp_rx_pkg.sv | 22 ++
 rtl/hp_sync_matcher.sv | 32 +++
 rtl/hp_rx_word_aligner.sv | 193 +++++++++++++++++++
 tb/tb_hp_rx_word_aligner.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp_rx_pkg.sv
// Shared types and helpers for the HP receive word aligner.
package hp_rx_pkg;

  // Aligner state: search for a sync byte, confirm its period, then track it.
  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLocked = 2'd2
  } align_state_e;

  localparam logic [7:0]  DefaultSyncWord = 8'hBC;
  localparam int unsigned DefaultFrameLen = 64;

  // Bits needed to hold the values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/hp_sync_matcher.sv
// Combinational sync-byte search across all eight bit offsets of a 16-bit window.
module hp_sync_matcher
  import hp_rx_pkg::*;
(
  input  logic [15:0] i_win,
  input  logic [7:0]  i_sync_word,
  output logic [7:0]  o_hit,
  output logic        o_any_hit,
  output logic [2:0]  o_hit_idx
);

  // Candidate at offset k starts k bits after the window's earliest bit.
  always_comb begin
    o_hit = '0;
    for (int k = 0; k < 8; k++) begin
      o_hit[k] = (i_win[15-k -: 8] == i_sync_word);
    end
  end

  assign o_any_hit = |o_hit;

  // Priority pick of the lowest matching offset; scanning downward lets the lowest win.
  always_comb begin
    o_hit_idx = '0;
    for (int k = 7; k >= 0; k--) begin
      if (o_hit[k]) begin
        o_hit_idx = 3'(k);
      end
    end
  end

endmodule

// File: rtl/hp_rx_word_aligner.sv
// Finds the bit offset of a periodic sync byte in deserialized words, locks onto it and
// emits byte-aligned data with frame-start and lock status plus a missed-sync counter.
module hp_rx_word_aligner
  import hp_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD    = DefaultSyncWord,
  parameter int unsigned FRAME_LEN    = DefaultFrameLen,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 3
) (
  input  logic        i_rx_clk,
  input  logic        i_free_run_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_en,
  output logic [7:0]  o_data_out,
  output logic        o_data_valid,
  output logic        o_sof,
  output logic        o_locked,
  output logic [2:0]  o_bit_offset,
  output logic [15:0] o_sync_err_cnt
);

  localparam int unsigned PosW  = cnt_width(FRAME_LEN);
  localparam int unsigned GoodW = cnt_width(LOCK_COUNT);
  localparam int unsigned MissW = cnt_width(UNLOCK_COUNT);

  localparam logic [PosW-1:0]  PosLast  = PosW'(FRAME_LEN - 1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_COUNT - 1);
  localparam logic [MissW-1:0] MissLast = MissW'(UNLOCK_COUNT - 1);

  align_state_e     r_state, w_state_nxt;
  logic [PosW-1:0]  r_pos, w_pos_nxt;
  logic [GoodW-1:0] r_good, w_good_nxt;
  logic [MissW-1:0] r_miss, w_miss_nxt;
  logic [7:0]       r_prev, w_prev_nxt;
  logic             r_primed, w_primed_nxt;
  logic [2:0]       r_bit_offset, w_bit_offset_nxt;
  logic [7:0]       r_data_out, w_data_out_nxt;
  logic             r_data_valid, w_data_valid_nxt;
  logic             r_sof, w_sof_nxt;
  logic             r_locked, w_locked_nxt;
  logic [15:0]      r_err, w_err_nxt;

  logic [15:0] w_win;
  logic [7:0]  w_hit;
  logic        w_any_hit;
  logic [2:0]  w_hit_idx;
  logic        w_slot;
  logic        w_sel_hit;
  logic [7:0]  w_sel_byte;

  assign w_win      = {r_prev, i_rx_data};
  assign w_slot     = (r_pos == '0);
  assign w_sel_hit  = w_hit[r_bit_offset];
  // Shift the chosen candidate down into the low byte of the window.
  assign w_sel_byte = 8'(w_win >> (4'd8 - {1'b0, r_bit_offset}));

  hp_sync_matcher u_matcher (
    .i_win       (w_win),
    .i_sync_word (SYNC_WORD),
    .o_hit       (w_hit),
    .o_any_hit   (w_any_hit),
    .o_hit_idx   (w_hit_idx)
  );

  // Next-state, counter and output-register logic; nothing advances without rx_en.
  always_comb begin
    w_state_nxt      = r_state;
    w_pos_nxt        = r_pos;
    w_good_nxt       = r_good;
    w_miss_nxt       = r_miss;
    w_prev_nxt       = r_prev;
    w_primed_nxt     = r_primed;
    w_bit_offset_nxt = r_bit_offset;
    w_data_out_nxt   = r_data_out;
    w_data_valid_nxt = 1'b0;
    w_sof_nxt        = 1'b0;
    w_err_nxt        = r_err;

    if (i_rx_en) begin
      w_prev_nxt   = i_rx_data;
      w_primed_nxt = 1'b1;
      w_pos_nxt    = (r_pos == PosLast) ? '0 : r_pos + 1'b1;

      // The very first word after reset only fills the window.
      if (r_primed) begin
        unique case (r_state)
          StHunt: begin
            if (w_any_hit) begin
              w_bit_offset_nxt = w_hit_idx;
              w_pos_nxt        = PosW'(1);
              w_good_nxt       = GoodW'(1);
              if (LOCK_COUNT == 1) begin
                w_state_nxt = StLocked;
                w_miss_nxt  = '0;
              end else begin
                w_state_nxt = StVerify;
              end
            end
          end

          StVerify: begin
            if (w_slot) begin
              if (w_sel_hit) begin
                if (r_good == GoodLast) begin
                  w_state_nxt = StLocked;
                  w_miss_nxt  = '0;
                end else begin
                  w_good_nxt = r_good + 1'b1;
                end
              end else begin
                w_state_nxt = StHunt;
              end
            end
          end

          StLocked: begin
            w_data_out_nxt   = w_sel_byte;
            w_data_valid_nxt = 1'b1;
            w_sof_nxt        = w_slot;
            if (w_slot) begin
              if (w_sel_hit) begin
                w_miss_nxt = '0;
              end else begin
                if (r_err != 16'hFFFF) begin
                  w_err_nxt = r_err + 16'd1;
                end
                if (r_miss == MissLast) begin
                  w_state_nxt = StHunt;
                  w_miss_nxt  = '0;
                end else begin
                  w_miss_nxt = r_miss + 1'b1;
                end
              end
            end
          end

          default: begin
            w_state_nxt = StHunt;
          end
        endcase
      end
    end

    w_locked_nxt = (w_state_nxt == StLocked);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_rx_clk) begin
    if (!i_free_run_rst_n) begin
      r_state  <= StHunt;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  // Window history, frame position, lock/miss counters and registered outputs.
  always_ff @(posedge i_rx_clk) begin
    if (!i_free_run_rst_n) begin
      r_pos        <= '0;
      r_good       <= '0;
      r_miss       <= '0;
      r_prev       <= '0;
      r_primed     <= 1'b0;
      r_bit_offset <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_sof        <= 1'b0;
      r_err        <= '0;
    end else begin
      r_pos        <= w_pos_nxt;
      r_good       <= w_good_nxt;
      r_miss       <= w_miss_nxt;
      r_prev       <= w_prev_nxt;
      r_primed     <= w_primed_nxt;
      r_bit_offset <= w_bit_offset_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_sof        <= w_sof_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign o_data_out     = r_data_out;
  assign o_data_valid   = r_data_valid;
  assign o_sof          = r_sof;
  assign o_locked       = r_locked;
  assign o_bit_offset   = r_bit_offset;
  assign o_sync_err_cnt = r_err;

endmodule

// File: tb/tb_hp_rx_word_aligner.sv
// Directed bench for hp_rx_word_aligner: bit-shifted frame streams, a word-indexed reference
// model checked every cycle, and hand-computed pins at the interesting words.
module tb_hp_rx_word_aligner;

  localparam logic [7:0] SYNC     = 8'hBC;
  localparam logic [7:0] BAD      = 8'h0A;
  localparam int         FLEN     = 64;
  localparam int         LOCK_N   = 4;
  localparam int         UNLOCK_N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_en;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        sof;
  logic        locked;
  logic [2:0]  bit_offset;
  logic [15:0] sync_err_cnt;

  always #5 clk = ~clk;

  hp_rx_word_aligner #(
    .SYNC_WORD    (SYNC),
    .FRAME_LEN    (FLEN),
    .LOCK_COUNT   (LOCK_N),
    .UNLOCK_COUNT (UNLOCK_N)
  ) dut (
    .i_rx_clk         (clk),
    .i_free_run_rst_n (rst_n),
    .i_rx_data        (rx_data),
    .i_rx_en          (rx_en),
    .o_data_out       (data_out),
    .o_data_valid     (data_valid),
    .o_sof            (sof),
    .o_locked         (locked),
    .o_bit_offset     (bit_offset),
    .o_sync_err_cnt   (sync_err_cnt)
  );

  // ---------------- reference model (word-indexed, slot = distance from acquisition) ----------
  int         m_mode;      // 0 searching, 1 confirming, 2 tracking
  int         m_off, m_anchor, m_n, m_good, m_miss, m_err;
  logic [7:0] m_prev, m_data;
  logic       m_have, m_valid, m_sof;

  // Expected outputs after the most recent clock edge.
  logic [7:0] e_data;
  logic       e_valid, e_sof, e_locked;
  logic [2:0] e_off;
  logic [15:0] e_err;
  logic       chk_on = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } pin_t;
  pin_t pin_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] byte_q[$];
  logic [7:0] word_q[$];
  int cur;
  int sof_seen, sof_bad, idle_valid;

  function automatic logic [7:0] pay(input int f, input int i);
    return 8'((f * 5 + i * 3) % 16);
  endfunction

  function automatic logic [7:0] cand(input logic [15:0] win, input int k);
    logic [15:0] t;
    t = win << k;
    return t[15:8];
  endfunction

  task automatic model(input logic en, input logic [7:0] d, input logic rst);
    logic [15:0] win;
    logic [7:0]  sel;
    int          idx;
    logic        slot;
    if (rst) begin
      m_mode = 0; m_off = 0; m_anchor = 0; m_n = 0; m_good = 0; m_miss = 0; m_err = 0;
      m_prev = 8'h00; m_have = 1'b0; m_data = 8'h00; m_valid = 1'b0; m_sof = 1'b0;
      return;
    end
    m_valid = 1'b0;
    m_sof   = 1'b0;
    if (!en) return;
    win = {m_prev, d};
    idx = m_n;
    m_n++;
    if (m_have) begin
      slot = ((idx - m_anchor) % FLEN) == 0;
      sel  = cand(win, m_off);
      if (m_mode == 0) begin
        for (int k = 0; k < 8; k++) begin
          if (cand(win, k) == SYNC) begin
            m_off = k; m_anchor = idx; m_good = 1; m_miss = 0;
            m_mode = (LOCK_N == 1) ? 2 : 1;
            break;
          end
        end
      end else if (m_mode == 1) begin
        if (slot) begin
          if (sel == SYNC) begin
            m_good++;
            if (m_good >= LOCK_N) begin
              m_mode = 2;
              m_miss = 0;
            end
          end else begin
            m_mode = 0;
          end
        end
      end else begin
        m_data  = sel;
        m_valid = 1'b1;
        m_sof   = slot;
        if (slot) begin
          if (sel == SYNC) begin
            m_miss = 0;
          end else begin
            if (m_err < 65535) m_err++;
            m_miss++;
            if (m_miss >= UNLOCK_N) m_mode = 0;
          end
        end
      end
    end
    m_prev = d;
    m_have = 1'b1;
  endtask

  // One clock cycle: drive inputs, advance the model, commit expectations at the edge.
  task automatic step(input logic en, input logic [7:0] d, input logic rst);
    rst_n   = ~rst;
    rx_en   = en;
    rx_data = d;
    model(en, d, rst);
    @(posedge clk);
    e_data   = m_data;
    e_valid  = m_valid;
    e_sof    = m_sof;
    e_locked = (m_mode == 2);
    e_off    = 3'(m_off);
    e_err    = 16'(m_err);
    chk_on   = 1'b1;
    #1;
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    pin_t p;
    p.name = name;
    p.got  = got;
    p.exp  = exp;
    pin_q.push_back(p);
  endtask

  task automatic add_frames(input int nf, input int bad_lo, input int bad_hi);
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < FLEN; i++) begin
        if (i == 0) byte_q.push_back((f >= bad_lo && f <= bad_hi) ? BAD : SYNC);
        else        byte_q.push_back(pay(f, i));
      end
    end
  endtask

  // Serialize byte_q MSB-first after `shift` leading zero bits, then cut into words.
  task automatic serialize(input int shift);
    logic       bits[$];
    logic [7:0] v;
    logic [7:0] b;
    word_q.delete();
    for (int s = 0; s < shift; s++) bits.push_back(1'b0);
    for (int i = 0; i < byte_q.size(); i++) begin
      b = byte_q[i];
      for (int j = 7; j >= 0; j--) bits.push_back(b[j]);
    end
    while ((bits.size() % 8) != 0) bits.push_back(1'b0);
    for (int w = 0; w < bits.size() / 8; w++) begin
      for (int j = 0; j < 8; j++) v[7-j] = bits[8*w + j];
      word_q.push_back(v);
    end
    cur = 0;
  endtask

  // Feed words up to index `last`, optionally inserting idle cycles with junk data.
  task automatic feed_to(input int last, input int idle_pct);
    while (cur <= last && cur < word_q.size()) begin
      if (idle_pct > 0 && $urandom_range(0, 99) < idle_pct) begin
        step(1'b0, 8'($urandom), 1'b0);
        if (data_valid) idle_valid++;
      end else begin
        step(1'b1, word_q[cur], 1'b0);
        cur++;
      end
      if (sof) sof_seen++;
      if (sof && !data_valid) sof_bad++;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Single compare process: model vs DUT every cycle, then any queued hand-computed pins.
  always @(negedge clk) begin
    pin_t p;
    if (chk_on) begin
      chk("data_out",     32'(data_out),     32'(e_data));
      chk("data_valid",   32'(data_valid),   32'(e_valid));
      chk("sof",          32'(sof),          32'(e_sof));
      chk("locked",       32'(locked),       32'(e_locked));
      chk("bit_offset",   32'(bit_offset),   32'(e_off));
      chk("sync_err_cnt", 32'(sync_err_cnt), 32'(e_err));
    end
    while (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      chk(p.name, p.got, p.exp);
    end
  end

  initial begin
    rst_n   = 1'b0;
    rx_en   = 1'b0;
    rx_data = 8'h00;
    sof_seen = 0; sof_bad = 0; idle_valid = 0;

    // Scenario A: offset 3, lock, two bad syncs, then a mid-frame reset and re-lock.
    do_reset();
    pin("rst_locked", 32'(locked), 0);
    pin("rst_valid",  32'(data_valid), 0);
    pin("rst_err",    32'(sync_err_cnt), 0);
    byte_q.delete();
    add_frames(14, 5, 6);
    serialize(3);
    feed_to(192, 0);
    pin("a_prelock", 32'(locked), 0);
    feed_to(193, 0);
    pin("a_lock", 32'(locked), 1);
    pin("a_off",  32'(bit_offset), 3);
    feed_to(194, 0);
    pin("a_first_valid", 32'(data_valid), 1);
    pin("a_first_byte",  32'(data_out), 32'h02);
    pin("a_first_sof",   32'(sof), 0);
    feed_to(257, 0);
    pin("a_sof",      32'(sof), 1);
    pin("a_sof_byte", 32'(data_out), 32'hBC);
    feed_to(385, 0);
    pin("a_err2",      32'(sync_err_cnt), 2);
    pin("a_hold_lock", 32'(locked), 1);
    pin("a_bad_sof",   32'(sof), 1);
    pin("a_bad_byte",  32'(data_out), 32'h0A);
    feed_to(449, 0);
    pin("a_err_after", 32'(sync_err_cnt), 2);
    pin("a_still_lock", 32'(locked), 1);
    feed_to(532, 0);
    do_reset();
    pin("a_rst_locked", 32'(locked), 0);
    pin("a_rst_valid",  32'(data_valid), 0);
    pin("a_rst_sof",    32'(sof), 0);
    pin("a_rst_data",   32'(data_out), 0);
    pin("a_rst_off",    32'(bit_offset), 0);
    pin("a_rst_err",    32'(sync_err_cnt), 0);
    feed_to(768, 0);
    pin("a_relock_pre", 32'(locked), 0);
    feed_to(769, 0);
    pin("a_relock", 32'(locked), 1);
    pin("a_relock_off", 32'(bit_offset), 3);
    feed_to(900, 0);

    // Scenario B: offset 6, three consecutive bad syncs drop lock.
    do_reset();
    byte_q.delete();
    add_frames(8, 4, 6);
    serialize(6);
    feed_to(193, 0);
    pin("b_lock", 32'(locked), 1);
    pin("b_off",  32'(bit_offset), 6);
    feed_to(384, 0);
    pin("b_err2", 32'(sync_err_cnt), 2);
    pin("b_lock2", 32'(locked), 1);
    feed_to(385, 0);
    pin("b_unlock",     32'(locked), 0);
    pin("b_last_valid", 32'(data_valid), 1);
    pin("b_last_sof",   32'(sof), 1);
    pin("b_last_byte",  32'(data_out), 32'h0A);
    pin("b_err3",       32'(sync_err_cnt), 3);
    feed_to(386, 0);
    pin("b_valid_drop", 32'(data_valid), 0);
    pin("b_off_hold",   32'(bit_offset), 6);
    feed_to(600, 0);

    // Scenario C: false sync at offset 5 in the preamble, true sync at offset 2.
    do_reset();
    byte_q.delete();
    for (int i = 0; i < 20; i++) begin
      if (i == 10)      byte_q.push_back(8'h17);
      else if (i == 11) byte_q.push_back(8'h80);
      else              byte_q.push_back(pay(9, i));
    end
    add_frames(6, 99, 99);
    serialize(2);
    feed_to(11, 0);
    pin("c_false_off", 32'(bit_offset), 5);
    pin("c_false_nolock", 32'(locked), 0);
    feed_to(85, 0);
    pin("c_true_off", 32'(bit_offset), 2);
    feed_to(276, 0);
    pin("c_prelock", 32'(locked), 0);
    feed_to(277, 0);
    pin("c_lock", 32'(locked), 1);
    pin("c_lock_off", 32'(bit_offset), 2);
    feed_to(500, 0);

    // Scenario D: offset 1, ~30% idle cycles once locked.
    do_reset();
    byte_q.delete();
    add_frames(9, 99, 99);
    serialize(1);
    feed_to(193, 0);
    pin("d_lock", 32'(locked), 1);
    feed_to(200, 0);
    sof_seen = 0; sof_bad = 0; idle_valid = 0;
    feed_to(576, 30);
    pin("d_sof_count",  32'(sof_seen), 5);
    pin("d_sof_idle",   32'(sof_bad), 0);
    pin("d_idle_valid", 32'(idle_valid), 0);
    pin("d_locked",     32'(locked), 1);
    pin("d_off",        32'(bit_offset), 1);

    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
